// File: rtl/mac_accumulator_pkg.sv
// Shared constants and state encoding for the MAC accumulate stage.
package mac_accumulator_pkg;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic {
        StAcc  = 1'b0,
        StDone = 1'b1
    } state_e;

endpackage

// File: rtl/mac_accumulator_sat_add.sv
// Unsigned ACC_W + PROD_W saturating adder; a set sticky input forces saturation.
module mac_accumulator_sat_add
    import mac_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W = 12
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    input  logic              ovf_in,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf_out
);

    logic [ACC_W:0] wide;

    always_comb begin
        wide    = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        ovf_out = wide[ACC_W] | ovf_in;
        sum     = ovf_out ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates a burst of multiplier products into a saturating sum and
// hands the total, term count and overflow flag downstream via valid/ready.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned MAX_TERMS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] p_in,
    input  logic              p_valid,
    input  logic              p_last,
    output logic              p_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  acc_count,
    output logic              acc_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    logic [ACC_W-1:0]   sum;
    logic               sum_ovf;
    logic               last_slot;

    mac_accumulator_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc     (acc_q),
        .prod    (p_in),
        .ovf_in  (ovf_q),
        .sum     (sum),
        .ovf_out (sum_ovf)
    );

    // The accept that fills the final slot closes the burst even without p_last.
    assign last_slot = (cnt_q == CNT_W'(MAX_TERMS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (p_valid) begin
                        acc_q <= sum;
                        ovf_q <= sum_ovf;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (p_last || last_slot) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    // No bypass: a term offered during the handshake cycle waits.
                    if (out_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= StAcc;
                    end
                end
                default: state_q <= StAcc;
            endcase
        end
    end

    assign p_ready   = (state_q == StAcc);
    assign out_valid = (state_q == StDone);
    assign acc_out   = acc_q;
    assign acc_count = cnt_q;
    assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench: two widths (12 and 10) driven in lockstep against a sum-of-products model.
module tb_mac_accumulator;

    localparam int unsigned MAX_TERMS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_in;
    logic       p_valid, p_last, out_ready;

    logic        p_ready_a, out_valid_a, acc_ovf_a;
    logic [11:0] acc_out_a;
    logic [4:0]  acc_count_a;
    logic        p_ready_b, out_valid_b, acc_ovf_b;
    logic [9:0]  acc_out_b;
    logic [4:0]  acc_count_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: burst is a plain running total; saturation derived from the total.
    bit     m_done;
    longint m_total;
    int     m_cnt;

    always #5 clk = ~clk;

    mac_accumulator #(.ACC_W(12), .MAX_TERMS(MAX_TERMS)) u_dut_a (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
        .p_ready(p_ready_a), .acc_out(acc_out_a), .acc_count(acc_count_a),
        .acc_ovf(acc_ovf_a), .out_valid(out_valid_a), .out_ready(out_ready)
    );

    mac_accumulator #(.ACC_W(10), .MAX_TERMS(MAX_TERMS)) u_dut_b (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
        .p_ready(p_ready_b), .acc_out(acc_out_b), .acc_count(acc_count_b),
        .acc_ovf(acc_ovf_b), .out_valid(out_valid_b), .out_ready(out_ready)
    );

    function automatic longint sat_of(input longint total, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (total > mx) ? mx : total;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done  = 1'b0;
            m_total = 0;
            m_cnt   = 0;
        end else if (!m_done) begin
            if (p_valid) begin
                m_total = m_total + longint'(p_in);
                m_cnt   = m_cnt + 1;
                if (p_last || m_cnt == MAX_TERMS) m_done = 1'b1;
            end
        end else if (out_ready) begin
            m_done  = 1'b0;
            m_total = 0;
            m_cnt   = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("p_ready_w12", longint'(p_ready_a), longint'(!m_done));
            check("out_valid_w12", longint'(out_valid_a), longint'(m_done));
            check("p_ready_w10", longint'(p_ready_b), longint'(!m_done));
            check("out_valid_w10", longint'(out_valid_b), longint'(m_done));
            if (m_done) begin
                check("acc_out_w12", longint'(acc_out_a), sat_of(m_total, 12));
                check("acc_count_w12", longint'(acc_count_a), longint'(m_cnt));
                check("acc_ovf_w12", longint'(acc_ovf_a), longint'(m_total > 4095));
                check("acc_out_w10", longint'(acc_out_b), sat_of(m_total, 10));
                check("acc_count_w10", longint'(acc_count_b), longint'(m_cnt));
                check("acc_ovf_w10", longint'(acc_ovf_b), longint'(m_total > 1023));
            end
        end
    end

    task automatic send(input logic [7:0] v, input logic last);
        int budget;
        budget  = 50;
        p_valid = 1'b1;
        p_in    = v;
        p_last  = last;
        while (!p_ready_a && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got p_ready=0 want p_ready=1");
        end
        @(posedge clk);
        #1;
        p_valid = 1'b0;
        p_last  = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_out_valid", longint'(out_valid_a), 0);
        check("release_p_ready", longint'(p_ready_a), 1);
    endtask

    initial begin
        rst = 1'b1; p_in = '0; p_valid = 1'b0; p_last = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_p_ready", longint'(p_ready_a), 1);
        check("rst_out_valid", longint'(out_valid_a), 0);
        check("rst_acc_out", longint'(acc_out_a), 0);
        check("rst_acc_count", longint'(acc_count_a), 0);
        check("rst_acc_ovf", longint'(acc_ovf_a), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst 9 + 12 + 25
        send(8'd9, 1'b0); send(8'd12, 1'b0); send(8'd25, 1'b1);
        check("basic_valid", longint'(out_valid_a), 1);
        check("basic_acc", longint'(acc_out_a), 46);
        check("basic_count", longint'(acc_count_a), 3);
        check("basic_ovf", longint'(acc_ovf_a), 0);
        release_out();

        // Auto-termination after 16 terms
        repeat (16) send(8'd225, 1'b0);
        check("auto_p_ready", longint'(p_ready_a), 0);
        check("auto_acc", longint'(acc_out_a), 3600);
        check("auto_count", longint'(acc_count_a), 16);
        check("auto_ovf", longint'(acc_ovf_a), 0);
        check("auto_acc_w10", longint'(acc_out_b), 1023);
        release_out();

        // Saturation at width 10, then a clean burst
        repeat (4) send(8'd225, 1'b0);
        send(8'd225, 1'b1);
        check("sat_acc_w10", longint'(acc_out_b), 1023);
        check("sat_ovf_w10", longint'(acc_ovf_b), 1);
        check("sat_count_w10", longint'(acc_count_b), 5);
        check("sat_acc_w12", longint'(acc_out_a), 1125);
        release_out();
        send(8'd49, 1'b1);
        check("post_sat_acc_w10", longint'(acc_out_b), 49);
        check("post_sat_ovf_w10", longint'(acc_ovf_b), 0);
        release_out();

        // Backpressure: held result, offered term ignored
        send(8'd25, 1'b0); send(8'd36, 1'b1);
        p_valid = 1'b1; p_in = 8'd100; p_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_acc", longint'(acc_out_a), 61);
            check("bp_count", longint'(acc_count_a), 2);
            check("bp_p_ready", longint'(p_ready_a), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_rel_valid", longint'(out_valid_a), 0);
        check("bp_rel_p_ready", longint'(p_ready_a), 1);
        @(posedge clk);
        #1;
        p_valid = 1'b0; p_last = 1'b0;
        check("bp_next_valid", longint'(out_valid_a), 1);
        check("bp_next_acc", longint'(acc_out_a), 100);
        release_out();

        // Asynchronous reset mid-burst
        send(8'd225, 1'b0); send(8'd225, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("amid_rst_valid", longint'(out_valid_a), 0);
        check("amid_rst_acc", longint'(acc_out_a), 0);
        check("amid_rst_count", longint'(acc_count_a), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'd15, 1'b1);
        check("after_rst_acc", longint'(acc_out_a), 15);
        check("after_rst_count", longint'(acc_count_a), 1);
        release_out();

        // Zero single-term burst
        send(8'd0, 1'b1);
        check("zero_valid", longint'(out_valid_a), 1);
        check("zero_acc", longint'(acc_out_a), 0);
        check("zero_count", longint'(acc_count_a), 1);
        check("zero_ovf", longint'(acc_ovf_a), 0);
        release_out();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            p_valid   = ($urandom_range(0, 3) != 0);
            p_in      = ($urandom_range(0, 3) == 0) ? 8'd225 : 8'($urandom_range(0, 255));
            p_last    = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (i == 400) begin
                #2;
                rst = 1'b1;
                #3;
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        p_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Sequential accumulate stage directly downstream of the 4x4 array multiplier. It consumes the 8-bit unsigned product stream through a valid/ready handshake and sums a burst of up to MAX_TERMS products into a saturating accumulator. The total, term count and overflow flag are presented through an output valid/ready handshake. Typical use is dot-product / MAC on the lab board, where the multiplier output is registered here.

Parameters:
ACC_W, 12, accumulator width in bits; legal range 8..16; 12 holds 16 x 225 = 3600 exactly.
MAX_TERMS, 16, burst auto-terminates after this many accepted terms; legal range 1..31.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
p_in  input  8  unsigned product from the multiplier stage.
p_valid  input  1  p_in is valid this cycle.
p_last  input  1  qualifies p_valid; this term closes the burst.
p_ready  output  1  stage accepts a term this cycle.
acc_out  output  ACC_W  accumulated sum, saturated.
acc_count  output  5  number of terms in the result.
acc_ovf  output  1  sum saturated at some point during the burst.
out_valid  output  1  result is valid.
out_ready  input  1  downstream accepts the result.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. On rst: state=ACC, accumulator=0, count=0, ovf=0, out_valid=0, p_ready=1 (p_ready is combinational from state).
- States:
  - ACC: p_ready=1, out_valid=0.
  - DONE: p_ready=0, out_valid=1.
- Accept in ACC: an accept occurs when p_valid && p_ready at a clock edge.
  - sum = {1'b0,acc} + p_in, computed ACC_W+1 bits wide.
  - If the sum carry is set or ovf is already 1: acc <= all ones, ovf <= 1.
  - Otherwise acc <= sum[ACC_W-1:0].
  - count <= count+1.
- ACC -> DONE: on an accept with p_last=1, or on an accept where count+1 == MAX_TERMS.
  - Latency: the term accepted at edge N is included in acc_out, and out_valid=1 after edge N (visible in cycle N+1).
- DONE: acc_out, acc_count and acc_ovf are held stable while out_valid && !out_ready.
  - p_valid is ignored in DONE; p_last is ignored unless p_valid.
- DONE -> ACC: on out_valid && out_ready.
  - acc, count and ovf are cleared at the same edge; p_ready=1 in the following cycle.
  - No same-cycle bypass; a term presented during that handshake cycle is not accepted.
- Outputs in ACC: acc_out and acc_count show live partial values; they are only meaningful when out_valid=1.
- Idle: p_valid=0 in ACC holds all state indefinitely; there is no timeout.
- Reset mid-burst: the partial sum is discarded with no output. Reset while in DONE drops the pending result.
- Edge values:
  - p_in=0 accepts normally and increments count.
  - Single-term burst (p_last on the first term) gives count=1.
  - acc_count never exceeds MAX_TERMS.

Decomposition:
- Shared include mac_defs.vh holds:
  - state encodings ST_ACC=1'b0, ST_DONE=1'b1;
  - product width constant PROD_W=8;
  - count width constant CNT_W=5.
- One sub-module, sat_add: ACC_W-bit + 8-bit unsigned saturating adder with sticky-overflow input. It is purely combinational and is instantiated once.

Test Plan:
- Basic burst: products 9, 12, 25 (3x3, 6x2, 5x5), p_last on 25 -> one cycle after the third accept: out_valid=1, acc_out=46, acc_count=3, acc_ovf=0.
- Auto-termination: 16 terms of 225 with p_last=0 -> p_ready drops after the 16th accept; acc_out=3600, acc_count=16, acc_ovf=0.
- Saturation, ACC_W=10 override: 5 terms of 225 with p_last on the 5th -> acc_out=1023, acc_ovf=1 (set at the 5th accept, sum 1125), acc_count=5; a following burst of 49 (7x7) with p_last -> acc_out=49, acc_ovf=0.
- Backpressure: after a burst of 25, 36 (sum 61), hold out_ready=0 for 5 cycles while driving p_valid=1, p_in=100 -> acc_out stays 61, p_ready=0, no term accepted. Then out_ready=1 -> out_valid=0 next cycle and p_ready=1; the next accepted 100 gives acc_out=100.
- Reset mid-burst: accept 225, 225, assert rst asynchronously between edges -> out_valid=0, acc_out=0, acc_count=0 immediately. After release, burst 15 with p_last -> acc_out=15, acc_count=1.
- Zero/single term: p_in=0 with p_last on the first accept -> acc_out=0, acc_count=1, acc_ovf=0, out_valid=1.
